systolic_array_mm: RTL

Parametrised successor to the fixed 4x4, 8-bit systolic matrix multiplier top. It computes C = A×B, or C = C + A×B in accumulate mode, for N×N matrices of W-bit elements. It owns its N×N multiply-accumulate PE grid internally, so there is no external core. Input is accepted with a valid/ready handshake and the result is held in an output register until the downstream consumer takes it.

---
 rtl/systolic_array_mm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/systolic_array_mm.sv
// N x N output-stationary systolic matrix multiplier: C = A*B or C += A*B.
// Operands enter through skewed shift registers; each PE owns one C element.
module systolic_array_mm #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int ACCW   = 2*W + $clog2(N) + 4,
    parameter int SIGNED = 0
) (
    input  logic                              i_clk,
    input  logic                              i_arst_n,
    input  logic [N-1:0][N-1:0][W-1:0]        i_a,
    input  logic [N-1:0][N-1:0][W-1:0]        i_b,
    input  logic                              i_accumulate,
    input  logic                              i_validInput,
    output logic                              o_ready,
    output logic [N-1:0][N-1:0][ACCW-1:0]     o_c,
    output logic                              o_validResult,
    input  logic                              i_resultReady
);

    localparam int SKL = 2*N - 1;
    localparam int CW  = $clog2(3*N - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]                     cnt;
    logic [N-1:0][SKL-1:0][W-1:0]      row_skew, col_skew;
    logic [N-1:0][SKL-1:0][W-1:0]      row_ld, col_ld;
    logic [N-1:0][N-2:0][W-1:0]        a_fwd;
    logic [N-2:0][N-1:0][W-1:0]        b_fwd;
    logic [N-1:0][N-1:0][W-1:0]        a_in, b_in;
    logic [N-1:0][N-1:0][ACCW-1:0]     acc;
    logic                              accept, run_done, mac_en;

    // Product is formed at 2W bits, then sign- or zero-extended to ACCW.
    function automatic logic [ACCW-1:0] ext_product(input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic signed [2*W-1:0]  sa;
        logic signed [2*W-1:0]  sb;
        logic signed [2*W-1:0]  prod;
        logic [ACCW+2*W-1:0]    wide;
        sa   = {{W{(SIGNED != 0) & a[W-1]}}, a};
        sb   = {{W{(SIGNED != 0) & b[W-1]}}, b};
        prod = sa * sb;
        wide = {{ACCW{(SIGNED != 0) & prod[2*W-1]}}, prod};
        return wide[ACCW-1:0];
    endfunction

    assign o_ready  = (state == IDLE);
    assign accept   = i_validInput & o_ready;
    assign run_done = (state == RUN) && (cnt == CW'(3*N - 2));
    assign mac_en   = (state == RUN) && !run_done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (run_done)      state_nxt = HOLD;
            HOLD:    if (i_resultReady) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Row r is preceded by r zeros and column c by c zeros, giving the diagonal wavefront.
    always_comb begin
        row_ld = '0;
        col_ld = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                row_ld[r][k+r] = i_a[r][k];
                col_ld[r][k+r] = i_b[k][r];
            end
        end
    end

    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int r = 0; r < N; r++) begin
            a_in[r][0] = row_skew[r][0];
            for (int c = 1; c < N; c++) a_in[r][c] = a_fwd[r][c-1];
        end
        for (int c = 0; c < N; c++) begin
            b_in[0][c] = col_skew[c][0];
            for (int r = 1; r < N; r++) b_in[r][c] = b_fwd[r-1][c];
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt           <= '0;
            row_skew      <= '0;
            col_skew      <= '0;
            a_fwd         <= '0;
            b_fwd         <= '0;
            acc           <= '0;
            o_c           <= '0;
            o_validResult <= 1'b0;
        end else begin
            if (accept) begin
                row_skew <= row_ld;
                col_skew <= col_ld;
                a_fwd    <= '0;
                b_fwd    <= '0;
                cnt      <= '0;
                if (!i_accumulate) acc <= '0;
            end else if (mac_en) begin
                cnt <= cnt + 1'b1;
                for (int r = 0; r < N; r++) begin
                    for (int j = 0; j < SKL-1; j++) begin
                        row_skew[r][j] <= row_skew[r][j+1];
                        col_skew[r][j] <= col_skew[r][j+1];
                    end
                    row_skew[r][SKL-1] <= '0;
                    col_skew[r][SKL-1] <= '0;
                end
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        acc[r][c] <= acc[r][c] + ext_product(a_in[r][c], b_in[r][c]);
                    end
                end
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N-1; c++) a_fwd[r][c] <= a_in[r][c];
                end
                for (int r = 0; r < N-1; r++) begin
                    for (int c = 0; c < N; c++) b_fwd[r][c] <= b_in[r][c];
                end
            end

            // Result register loads once the last MAC has landed in the accumulators.
            if (run_done) begin
                o_c           <= acc;
                o_validResult <= 1'b1;
            end else if ((state == HOLD) && i_resultReady) begin
                o_validResult <= 1'b0;
            end
        end
    end

endmodule
